mem_arbiter: RTL

- Shares the single-port block RAM (8-bit address, 16-bit data, 1-cycle registered read, read-before-write) between two requesters.
- Port 0 is the TinyMIPS core memory interface; port 1 is the host/debug loader (program download, result readback).
- Per-port request/grant handshake, round-robin or fixed priority, optional bounded lock for atomic multi-access sequences, and a read-data-valid return path.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_if.sv | 26 ++
 rtl/mem_arbiter_rr_arb2.sv | 81 ++++++++
 rtl/mem_arbiter.sv | 73 +++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the TinyMIPS block-RAM arbiter.
// Both requesters and the RAM use these widths.
package tinymips_mem_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;

   typedef logic [0:0] port_idx_t;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester's memory port: request/grant handshake plus the read return path.
// master = requester side, slave = arbiter side.
interface mem_arbiter_if
   import tinymips_mem_pkg::*;
();

   logic              req;
   logic              we;
   logic              lock;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              gnt;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, lock, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, lock, addr, wdata,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way grant logic: round-robin or fixed priority, with a bounded lock
// that lets one port keep the grant for a short atomic sequence.
module rr_arb2
   import tinymips_mem_pkg::*;
#(
   parameter int FIXED_PRIO = 0,
   parameter int MAX_LOCK   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [1:0] lock,
   output logic [1:0] gnt
);

   localparam logic [3:0] MaxCnt = 4'(MAX_LOCK);

   arb_state_e state_q, state_d;
   port_idx_t  last_q, last_d;
   port_idx_t  owner_q, owner_d;
   logic [3:0] lock_cnt_q, lock_cnt_d;
   logic [3:0] cnt_inc;
   port_idx_t  win;

   // An idle owner drops its lock on the spot so the other port can use that cycle.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      owner_d    = owner_q;
      lock_cnt_d = lock_cnt_q;
      gnt        = 2'b00;
      win        = last_q;
      cnt_inc    = (lock_cnt_q == 4'hF) ? lock_cnt_q : lock_cnt_q + 4'd1;

      if (rst) begin
         gnt = 2'b00;
      end else if (state_q == LOCKED && req[owner_q]) begin
         win          = owner_q;
         gnt[owner_q] = 1'b1;
         last_d       = owner_q;
         lock_cnt_d   = cnt_inc;
         if (!(lock[owner_q] && cnt_inc < MaxCnt)) begin
            state_d    = ARB;
            lock_cnt_d = 4'd0;
         end
      end else begin
         state_d    = ARB;
         lock_cnt_d = 4'd0;
         if (req != 2'b00) begin
            if (req == 2'b11) begin
               win = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
            end else begin
               win = req[1];
            end
            gnt[win] = 1'b1;
            last_d   = win;
            // A single-grant budget never needs the LOCKED state.
            if (lock[win] && MaxCnt > 4'd1) begin
               state_d    = LOCKED;
               owner_d    = win;
               lock_cnt_d = 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ARB;
         last_q     <= 1'b1;
         owner_q    <= 1'b0;
         lock_cnt_q <= 4'd0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         owner_q    <= owner_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port block RAM between the TinyMIPS core (p0) and the
// host/debug loader (p1); adds the RAM mux and the registered read-valid return.
module mem_arbiter
   import tinymips_mem_pkg::*;
#(
   parameter int FIXED_PRIO = 0,
   parameter int MAX_LOCK   = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_arbiter_if.slave      p0,
   mem_arbiter_if.slave      p1,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   logic [1:0] gnt;
   logic       p0_rvalid_q, p0_rvalid_d;
   logic       p1_rvalid_q, p1_rvalid_d;

   rr_arb2 #(
      .FIXED_PRIO (FIXED_PRIO),
      .MAX_LOCK   (MAX_LOCK)
   ) u_arb (
      .clk  (clk),
      .rst  (rst),
      .req  ({p1.req, p0.req}),
      .lock ({p1.lock, p0.lock}),
      .gnt  (gnt)
   );

   assign p0.gnt = gnt[0];
   assign p1.gnt = gnt[1];

   // Idle bus is all zeros so the RAM never sees a stray write.
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_din  = '0;
      if (gnt[0]) begin
         ram_we   = p0.we;
         ram_addr = p0.addr;
         ram_din  = p0.wdata;
      end else if (gnt[1]) begin
         ram_we   = p1.we;
         ram_addr = p1.addr;
         ram_din  = p1.wdata;
      end
   end

   always_comb begin
      p0_rvalid_d = gnt[0] & ~p0.we;
      p1_rvalid_d = gnt[1] & ~p1.we;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p0_rvalid_q <= 1'b0;
         p1_rvalid_q <= 1'b0;
      end else begin
         p0_rvalid_q <= p0_rvalid_d;
         p1_rvalid_q <= p1_rvalid_d;
      end
   end

   assign p0.rvalid = p0_rvalid_q;
   assign p1.rvalid = p1_rvalid_q;
   assign p0.rdata  = ram_dout;
   assign p1.rdata  = ram_dout;

endmodule
